cp0_ctrl: RTL and testbench

Parametrised coprocessor-0 / exception controller for the five-stage MIPS pipeline, positioned at the MEM stage. It supersedes the fixed six-line CP0 with:
- a configurable number of hardware interrupt lines;
- a per-line level/edge mode;
- an internal Count/Compare timer interrupt;
- defined precedence for every simultaneous event.

The CPU top consumes `irq_req` to flush all stages and redirect the PC to the handler. It consumes `epc` for `eret`.

---
 rtl/cp0_pkg.sv | 35 +++
 rtl/cp0_int_latch.sv | 41 ++++
 rtl/cp0_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cp0_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 / exception controller.
// Holds the CP0 register numbers, the bit positions of the SR/Cause fields
// and the ExcCode values that the pipeline carries into the M stage.
package cp0_pkg;

    // CP0 register numbers (the rd field of mfc0/mtc0)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    // Field bit positions; IM and IP share the same low bit position
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LO    = 10;
    localparam int EXC_LO   = 2;
    localparam int CAUSE_BD = 31;

    // Exception codes carried in Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // EPC always holds a word address
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_int_latch.sv
// cp0_int_latch: per-line capture of the external interrupt lines into the
// Cause.IP bits. Level lines simply follow the input; edge lines latch a
// rising edge and hold it until software writes a 0 to that IP bit.
// Ports:
//   clk, reset    - clock, synchronous active-low reset
//   hw_int [W]    - raw interrupt lines
//   clr_en        - an mtc0 to Cause is accepted this cycle
//   clr_data [W]  - written IP bits (0 clears an edge bit, 1 leaves it)
//   ip [W]        - captured pending bits
module cp0_int_latch #(
    parameter int         W         = 6,
    parameter logic [W-1:0] EDGE_MASK = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] hw_int,
    input  logic         clr_en,
    input  logic [W-1:0] clr_data,
    output logic [W-1:0] ip
);

    logic [W-1:0] prev;
    logic [W-1:0] rise;
    logic [W-1:0] keep;

    assign rise = hw_int & ~prev;
    assign keep = clr_en ? clr_data : '1;

    // The rising edge is OR-ed in after the clear so an edge arriving in
    // the same cycle as a clearing write is not lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= '0;
            ip   <= '0;
        end else begin
            prev <= hw_int;
            ip   <= (EDGE_MASK & ((ip & keep) | rise)) | (~EDGE_MASK & hw_int);
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 / exception controller sitting at the MEM stage.
// Implements SR, Cause, EPC, PRId, Count and Compare, a Count/Compare timer
// interrupt on IP bit N_INT and N_INT external lines with per-line
// level/edge capture. irq_req tells the CPU to flush and vector.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   we, addr, din, dout   - mtc0 write / mfc0 read port
//   pc_m, bd_m            - PC and delay-slot flag of the M-stage instruction
//   exc_code_m            - synchronous exception code in M (0 = none)
//   eret_m                - eret in M
//   hw_int                - external interrupt lines
//   irq_req, epc, exl     - take-exception request, current EPC, SR.EXL
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int               N_INT     = 6,
    parameter logic [N_INT-1:0] EDGE_MASK = '0,
    parameter logic [31:0]      PRID      = 32'h0000_4D49
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    input  logic [31:0]      pc_m,
    input  logic             bd_m,
    input  logic [4:0]       exc_code_m,
    input  logic             eret_m,
    input  logic [N_INT-1:0] hw_int,
    output logic             irq_req,
    output logic [31:0]      epc,
    output logic             exl
);

    localparam int NIP = N_INT + 1;

    logic             ie;
    logic             exl_q;
    logic [NIP-1:0]   im;
    logic             bd;
    logic [4:0]       exc_code;
    logic [31:0]      epc_q;
    logic [31:0]      count;
    logic [31:0]      compare;
    logic             timer_pend;
    logic [N_INT-1:0] ext_ip;
    logic [NIP-1:0]   ip;
    logic             int_pend;
    logic             exc_pend;
    logic             wr;
    logic             wr_sr;
    logic             wr_cause;
    logic             wr_epc;
    logic             wr_count;
    logic             wr_compare;
    logic [31:0]      sr_rd;
    logic [31:0]      cause_rd;

    cp0_int_latch #(
        .W         (N_INT),
        .EDGE_MASK (EDGE_MASK)
    ) u_int_latch (
        .clk      (clk),
        .reset    (reset),
        .hw_int   (hw_int),
        .clr_en   (wr_cause),
        .clr_data (din[IM_LO +: N_INT]),
        .ip       (ext_ip)
    );

    assign ip = {timer_pend, ext_ip};

    // Gating with reset keeps the request low throughout reset.
    assign int_pend = (|(ip & im)) & ie & ~exl_q;
    assign exc_pend = (exc_code_m != 5'd0) & ~exl_q;
    assign irq_req  = reset & (int_pend | exc_pend);

    // A taken exception discards any mtc0 of the same cycle.
    assign wr         = we & ~irq_req;
    assign wr_sr      = wr & (addr == REG_SR);
    assign wr_cause   = wr & (addr == REG_CAUSE);
    assign wr_epc     = wr & (addr == REG_EPC);
    assign wr_count   = wr & (addr == REG_COUNT);
    assign wr_compare = wr & (addr == REG_COMPARE);

    // Count/Compare timer. A Compare write wins over a match in the same
    // cycle, so the pending bit is cleared rather than set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            compare    <= 32'hFFFF_FFFF;
            timer_pend <= 1'b0;
        end else begin
            count <= wr_count ? din : count + 32'd1;
            if (wr_compare) begin
                compare    <= din;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end

    // Exception entry overrides eret and mtc0. Without it, eret clears EXL
    // after any SR write so the clear wins over the written EXL bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ie       <= 1'b0;
            exl_q    <= 1'b0;
            im       <= '0;
            bd       <= 1'b0;
            exc_code <= EXC_INT;
            epc_q    <= '0;
        end else if (irq_req) begin
            exl_q    <= 1'b1;
            bd       <= bd_m;
            epc_q    <= word_align(bd_m ? pc_m - 32'd4 : pc_m);
            exc_code <= int_pend ? EXC_INT : exc_code_m;
        end else begin
            if (wr_sr) begin
                im    <= din[IM_LO +: NIP];
                ie    <= din[SR_IE];
                exl_q <= din[SR_EXL];
            end
            if (eret_m) begin
                exl_q <= 1'b0;
            end
            if (wr_epc) begin
                epc_q <= word_align(din);
            end
        end
    end

    always_comb begin
        sr_rd                  = '0;
        sr_rd[IM_LO +: NIP]    = im;
        sr_rd[SR_EXL]          = exl_q;
        sr_rd[SR_IE]           = ie;
        cause_rd               = '0;
        cause_rd[CAUSE_BD]     = bd;
        cause_rd[IM_LO +: NIP] = ip;
        cause_rd[EXC_LO +: 5]  = exc_code;
    end

    always_comb begin
        dout = '0;
        case (addr)
            REG_SR:      dout = sr_rd;
            REG_CAUSE:   dout = cause_rd;
            REG_EPC:     dout = epc_q;
            REG_PRID:    dout = PRID;
            REG_COUNT:   dout = count;
            REG_COMPARE: dout = compare;
            default:     dout = '0;
        endcase
    end

    assign epc = epc_q;
    assign exl = exl_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed, table-driven bench for cp0_ctrl with line 0 edge
// sensitive and lines 1..5 level sensitive. Each table row is one clock
// cycle: inputs are driven after the falling edge and the combinational
// outputs (which reflect the state from earlier rows) are compared before
// the next rising edge. Timer, Count wrap and mid-run reset follow as
// hand-written sequences.
module tb_cp0_ctrl;

    import cp0_pkg::*;

    localparam int          N_INT = 6;
    localparam logic [31:0] PRID  = 32'h0000_4D49;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             we = 1'b0;
    logic [4:0]       addr = '0;
    logic [31:0]      din = '0;
    logic [31:0]      dout;
    logic [31:0]      pc_m = '0;
    logic             bd_m = 1'b0;
    logic [4:0]       exc_code_m = '0;
    logic             eret_m = 1'b0;
    logic [N_INT-1:0] hw_int = '1;
    logic             irq_req;
    logic [31:0]      epc;
    logic             exl;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        er;
        logic [5:0]  hw;
        logic        x_irq;
        logic [31:0] x_dout;
        logic [31:0] x_epc;
        logic        x_exl;
    } vec_t;

    vec_t vecs[$];

    cp0_ctrl #(
        .N_INT     (N_INT),
        .EDGE_MASK (6'b000001),
        .PRID      (PRID)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exc_code_m (exc_code_m),
        .eret_m     (eret_m),
        .hw_int     (hw_int),
        .irq_req    (irq_req),
        .epc        (epc),
        .exl        (exl)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic w, input logic [4:0] a,
                                input logic [31:0] d, input logic [31:0] pc, input logic bd,
                                input logic [4:0] exc, input logic er, input logic [5:0] hw,
                                input logic xi, input logic [31:0] xd, input logic [31:0] xe,
                                input logic xx);
        vec_t v;
        v.rst = rst; v.w = w; v.a = a; v.d = d; v.pc = pc; v.bd = bd;
        v.exc = exc; v.er = er; v.hw = hw;
        v.x_irq = xi; v.x_dout = xd; v.x_epc = xe; v.x_exl = xx;
        return v;
    endfunction

    // Drive one cycle of inputs after the falling edge and let them settle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset      = v.rst;
        we         = v.w;
        addr       = v.a;
        din        = v.d;
        pc_m       = v.pc;
        bd_m       = v.bd;
        exc_code_m = v.exc;
        eret_m     = v.er;
        hw_int     = v.hw;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Short-hand for the hand-written sequences: no exception, lines quiet.
    task automatic drive(input logic rst, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic er);
        applyStimulus(mk(rst, w, a, d, 32'h4000, 1'b0, 5'd0, er, 6'h00,
                         1'b0, 32'h0, 32'h0, 1'b0));
    endtask

    initial begin
        //                 rst w  addr  din            pc         bd  exc er  hw      irq dout           epc        exl
        // reset held low with all lines high
        vecs.push_back(mk(0, 0, 5'd12, 32'h0,        32'h0,     0, 5'd0, 0, 6'h3F, 0, 32'h0,        32'h0,    0));
        vecs.push_back(mk(0, 0, 5'd15, 32'h0,        32'h0,     0, 5'd0, 0, 6'h3F, 0, PRID,         32'h0,    0));
        vecs.push_back(mk(0, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h3F, 0, 32'h0,        32'h0,    0));
        vecs.push_back(mk(1, 0, 5'd9,  32'h0,        32'h0,     0, 5'd0, 0, 6'h3F, 0, 32'h0,        32'h0,    0));
        // IP follows the lines; clear the latched edge, enable IM[15:10] + IE
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0000_FC00, 32'h0,   0));
        vecs.push_back(mk(1, 1, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0000_0400, 32'h0,   0));
        vecs.push_back(mk(1, 1, 5'd12, 32'h0000_FC01, 32'h0,    0, 5'd0, 0, 6'h00, 0, 32'h0,        32'h0,    0));
        // level interrupt on line 2
        vecs.push_back(mk(1, 0, 5'd12, 32'h0,        32'h0,     0, 5'd0, 0, 6'h04, 0, 32'h0000_FC01, 32'h0,   0));
        vecs.push_back(mk(1, 0, 5'd14, 32'h0,        32'h3010,  0, 5'd0, 0, 6'h04, 1, 32'h0,        32'h0,    0));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h0C, 0, 32'h0000_1000, 32'h3010, 1));
        vecs.push_back(mk(1, 0, 5'd12, 32'h0,        32'h0,     0, 5'd0, 0, 6'h0C, 0, 32'h0000_FC03, 32'h3010, 1));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 1, 6'h00, 0, 32'h0000_3000, 32'h3010, 1));
        vecs.push_back(mk(1, 0, 5'd12, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0000_FC01, 32'h3010, 0));
        // edge interrupt on line 0: one-cycle pulse
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h01, 0, 32'h0,        32'h3010, 0));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h3020,  0, 5'd0, 0, 6'h00, 1, 32'h0000_0400, 32'h3010, 0));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0000_0400, 32'h3020, 1));
        vecs.push_back(mk(1, 0, 5'd12, 32'h0,        32'h0,     0, 5'd0, 1, 6'h00, 0, 32'h0000_FC03, 32'h3020, 1));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h3024,  0, 5'd0, 0, 6'h00, 1, 32'h0000_0400, 32'h3020, 0));
        vecs.push_back(mk(1, 1, 5'd13, 32'h0,        32'h0,     0, 5'd0, 1, 6'h00, 0, 32'h0000_0400, 32'h3024, 1));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0,        32'h3024, 0));
        // rising edge together with a clearing write: the edge survives
        vecs.push_back(mk(1, 1, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h01, 0, 32'h0,        32'h3024, 0));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h3028,  0, 5'd0, 0, 6'h00, 1, 32'h0000_0400, 32'h3024, 0));
        vecs.push_back(mk(1, 1, 5'd13, 32'h0,        32'h0,     0, 5'd0, 1, 6'h00, 0, 32'h0000_0400, 32'h3028, 1));
        // overflow in a delay slot with line 1 pending; mtc0 EPC discarded
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h02, 0, 32'h0,        32'h3028, 0));
        vecs.push_back(mk(1, 1, 5'd14, 32'hDEAD_BEE0, 32'h3008, 1, 5'd12, 0, 6'h02, 1, 32'h3028,    32'h3028, 0));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h8000_0800, 32'h3004, 1));
        vecs.push_back(mk(1, 0, 5'd14, 32'h0,        32'h0,     0, 5'd0, 1, 6'h00, 0, 32'h3004,     32'h3004, 1));
        // plain exception with unaligned PC
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h3031,  0, 5'd5, 0, 6'h00, 1, 32'h8000_0000, 32'h3004, 0));
        vecs.push_back(mk(1, 0, 5'd13, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0000_0014, 32'h3030, 1));
        // eret overrides the EXL bit of a same-cycle SR write
        vecs.push_back(mk(1, 1, 5'd12, 32'h0001_0003, 32'h0,    0, 5'd0, 1, 6'h00, 0, 32'h0000_FC03, 32'h3030, 1));
        vecs.push_back(mk(1, 0, 5'd12, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0001_0001, 32'h3030, 0));
        // EPC write is word-aligned; unmapped address reads 0
        vecs.push_back(mk(1, 1, 5'd14, 32'h0000_1237, 32'h0,    0, 5'd0, 0, 6'h00, 0, 32'h3030,     32'h3030, 0));
        vecs.push_back(mk(1, 0, 5'd14, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h1234,     32'h1234, 0));
        vecs.push_back(mk(1, 1, 5'd20, 32'hFFFF_FFFF, 32'h0,    0, 5'd0, 0, 6'h00, 0, 32'h0,        32'h1234, 0));
        vecs.push_back(mk(1, 0, 5'd20, 32'h0,        32'h0,     0, 5'd0, 0, 6'h00, 0, 32'h0,        32'h1234, 0));

        // one reset edge so every register has a defined value
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d.irq", i),  32'(irq_req), 32'(vecs[i].x_irq));
            checkOutput($sformatf("vec%0d.dout", i), dout,         vecs[i].x_dout);
            checkOutput($sformatf("vec%0d.epc", i),  epc,          vecs[i].x_epc);
            checkOutput($sformatf("vec%0d.exl", i),  32'(exl),     32'(vecs[i].x_exl));
        end

        // Timer: Compare = 5, Count = 0, only the timer line enabled
        drive(1, 1, REG_COMPARE, 32'd5, 0);
        drive(1, 1, REG_COUNT, 32'd0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, REG_COUNT, 32'd0, 0);
            checkOutput($sformatf("timer.count%0d", i), dout, 32'(i));
            checkOutput($sformatf("timer.irq_at%0d", i), 32'(irq_req), 32'd0);
        end
        drive(1, 0, REG_CAUSE, 32'd0, 0);
        checkOutput("timer.irq", 32'(irq_req), 32'd1);
        checkOutput("timer.cause", dout, 32'h0001_0014);
        drive(1, 1, REG_COMPARE, 32'd1000, 0);
        checkOutput("timer.exl", 32'(exl), 32'd1);
        checkOutput("timer.epc", epc, 32'h4000);
        drive(1, 0, REG_CAUSE, 32'd0, 1);
        checkOutput("timer.cleared", dout, 32'h0);
        drive(1, 0, REG_CAUSE, 32'd0, 0);
        checkOutput("timer.irq_off", 32'(irq_req), 32'd0);
        checkOutput("timer.exl_off", 32'(exl), 32'd0);

        // Count wrap with Compare = 1
        drive(1, 1, REG_COMPARE, 32'd1, 0);
        drive(1, 1, REG_COUNT, 32'hFFFF_FFFF, 0);
        drive(1, 0, REG_COUNT, 32'd0, 0);
        checkOutput("wrap.max", dout, 32'hFFFF_FFFF);
        drive(1, 0, REG_COUNT, 32'd0, 0);
        checkOutput("wrap.zero", dout, 32'h0);
        checkOutput("wrap.irq0", 32'(irq_req), 32'd0);
        drive(1, 0, REG_COUNT, 32'd0, 0);
        checkOutput("wrap.one", dout, 32'd1);
        checkOutput("wrap.irq1", 32'(irq_req), 32'd0);
        drive(1, 0, REG_CAUSE, 32'd0, 0);
        checkOutput("wrap.match_irq", 32'(irq_req), 32'd1);

        // Reset mid-operation with the timer request pending
        drive(0, 0, REG_CAUSE, 32'd0, 0);
        checkOutput("rst.irq_low", 32'(irq_req), 32'd0);
        drive(1, 0, REG_COMPARE, 32'd0, 0);
        checkOutput("rst.compare", dout, 32'hFFFF_FFFF);
        checkOutput("rst.epc", epc, 32'h0);
        checkOutput("rst.exl", 32'(exl), 32'd0);
        drive(1, 0, REG_CAUSE, 32'd0, 0);
        checkOutput("rst.cause", dout, 32'h0);
        checkOutput("rst.irq", 32'(irq_req), 32'd0);
        drive(1, 0, REG_SR, 32'd0, 0);
        checkOutput("rst.sr", dout, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
